// File: rtl/uart_tx_framer_pkg.sv
// uart_tx_framer_pkg: frame constants, FSM state encoding and shared helpers
package uart_tx_framer_pkg;
   localparam logic [7:0] FRAME_HDR = 8'hA5;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FIRE = 2'd2,
      WAIT = 2'd3
   } state_t;
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction
endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: periodic one-cycle tick every PERIOD_MS milliseconds while enabled
module uart_tick_gen #(
   parameter int CLK_FRE   = 50,
   parameter int PERIOD_MS = 10
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);
   localparam int N = PERIOD_MS * CLK_FRE * 1000;
   localparam int W = (N > 1) ? $clog2(N) : 1;
   logic [W-1:0] cnt_q, cnt_d;
   assign tick = en && (cnt_q == W'(N - 1));
   always_comb cnt_d = (!en || tick) ? '0 : cnt_q + W'(1);
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: builds header/seq/payload/checksum frames and hands them to a UART transmitter
module uart_tx_framer
   import uart_tx_framer_pkg::*;
#(
   parameter int BSN         = 4,
   parameter int CLK_FRE     = 50,
   parameter int PERIOD_MS   = 10,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                 sys_clk,
   input  logic                 rst_n,
   input  logic                 trig,
   input  logic                 periodic_en,
   input  logic [(BSN-3)*8-1:0] payload,
   input  logic                 uart_send_comlete,
   output logic                 uart_send_flag,
   output logic [BSN*8-1:0]     dataT,
   output logic                 busy,
   output logic [7:0]           seq,
   output logic                 tx_err,
   output logic [7:0]           drop_cnt
);
   localparam int IW = $clog2(BSN);
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [7:0]       acc_q, acc_d;
   logic [TW-1:0]    to_q, to_d;
   logic [7:0]       seq_q, seq_d;
   logic [7:0]       drop_q, drop_d;
   logic [BSN*8-1:0] data_q, data_d;
   logic             pend_q, pend_d;
   logic             comp_q, comp_d;
   logic             flag_q, flag_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             tick, req, rise, timeout, load;
   logic [7:0]       cur;
   uart_tick_gen #(.CLK_FRE(CLK_FRE), .PERIOD_MS(PERIOD_MS)) u_tick (
      .sys_clk(sys_clk),
      .rst_n  (rst_n),
      .en     (periodic_en),
      .tick   (tick)
   );
   assign req     = trig | tick;
   assign rise    = uart_send_comlete & ~comp_q;
   assign timeout = to_q == TW'(TIMEOUT_CYC - 1);
   assign comp_d  = uart_send_comlete;
   always_comb begin
      cur = '0;
      for (int k = 0; k < BSN; k++) cur = (idx_q == IW'(k)) ? data_q[(BSN-1-k)*8 +: 8] : cur;
   end
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      to_d    = to_q;
      seq_d   = seq_q;
      drop_d  = drop_q;
      data_d  = data_q;
      pend_d  = pend_q;
      flag_d  = 1'b0;
      err_d   = 1'b0;
      load    = 1'b0;
      // a request arriving while busy is captured before any WAIT exit decision
      if (req && state_q != IDLE) begin
         pend_d = 1'b1;
         drop_d = pend_q ? sat_inc(drop_q) : drop_q;
      end
      case (state_q)
         IDLE: load = req;
         LOAD: begin
            acc_d = acc_q + cur;
            idx_d = idx_q + IW'(1);
            if (idx_q == IW'(BSN - 2)) begin
               data_d[7:0] = acc_q + cur;
               state_d     = FIRE;
               flag_d      = 1'b1;
            end
         end
         FIRE: begin
            to_d    = '0;
            state_d = WAIT;
         end
         WAIT: begin
            to_d  = to_q + TW'(1);
            seq_d = rise ? seq_q + 8'd1 : seq_q;
            err_d = !rise && timeout;
            if (rise || timeout) begin
               load    = pend_d;
               pend_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: ;
      endcase
      if (load) begin
         data_d  = {FRAME_HDR, seq_d, payload, 8'h00};
         acc_d   = '0;
         idx_d   = '0;
         state_d = LOAD;
      end
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         acc_q   <= '0;
         to_q    <= '0;
         seq_q   <= '0;
         drop_q  <= '0;
         data_q  <= '0;
         pend_q  <= 1'b0;
         comp_q  <= 1'b0;
         flag_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         to_q    <= to_d;
         seq_q   <= seq_d;
         drop_q  <= drop_d;
         data_q  <= data_d;
         pend_q  <= pend_d;
         comp_q  <= comp_d;
         flag_q  <= flag_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end
   assign uart_send_flag = flag_q;
   assign dataT          = data_q;
   assign busy           = busy_q;
   assign seq            = seq_q;
   assign tx_err         = err_q;
   assign drop_cnt       = drop_q;
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: directed and randomized frames checked against a frame-level reference model
module tb_uart_tx_framer;
   localparam int BSN = 4, CLK_FRE = 1, PERIOD_MS = 1, TIMEOUT_CYC = 40;
   localparam int TICK_N = PERIOD_MS * CLK_FRE * 1000;
   logic        sys_clk = 1'b0, rst_n = 1'b0, trig = 1'b0, periodic_en = 1'b0, uart_send_comlete = 1'b0;
   logic [7:0]  payload = '0;
   logic        uart_send_flag, busy, tx_err;
   logic [31:0] dataT;
   logic [7:0]  seq, drop_cnt;
   logic [7:0]  exp_seq = '0;
   logic [31:0] fr;
   int          total = 0, bad = 0, n, nf;
   uart_tx_framer #(.BSN(BSN), .CLK_FRE(CLK_FRE), .PERIOD_MS(PERIOD_MS), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .sys_clk(sys_clk), .rst_n(rst_n), .trig(trig), .periodic_en(periodic_en), .payload(payload),
      .uart_send_comlete(uart_send_comlete), .uart_send_flag(uart_send_flag), .dataT(dataT),
      .busy(busy), .seq(seq), .tx_err(tx_err), .drop_cnt(drop_cnt)
   );
   always #5 sys_clk = ~sys_clk;
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
   function automatic logic [31:0] model_frame(input logic [7:0] s, input logic [7:0] p);
      logic [7:0] sum;
      sum = 8'hA5 + s + p;
      return {8'hA5, s, p, sum};
   endfunction
   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic wait_flag(output int k);
      k = 0;
      while (!uart_send_flag && k < 60) begin
         step();
         k++;
      end
      check("flag_seen", 32'(uart_send_flag), 32'd1);
   endtask
   task automatic run(input int cyc, output int cnt);
      logic arm;
      arm = 1'b0;
      cnt = 0;
      for (int i = 0; i < cyc; i++) begin
         step();
         uart_send_comlete = arm;
         arm = uart_send_flag;
         cnt += int'(uart_send_flag);
         exp_seq += 8'(int'(uart_send_comlete));
      end
      uart_send_comlete = 1'b0;
   endtask
   task automatic do_frame(input logic [7:0] p, input int gap, input int hold, output logic [31:0] f);
      int k;
      payload = p;
      trig = 1'b1;
      step();
      trig = 1'b0;
      wait_flag(k);
      f = dataT;
      check("latency", 32'(k), 32'(BSN - 1));
      check("dataT", dataT, model_frame(exp_seq, p));
      check("busy_hi", 32'(busy), 32'd1);
      step();
      check("flag_1cyc", 32'(uart_send_flag), 32'd0);
      repeat (gap - 1) step();
      uart_send_comlete = 1'b1;
      step();
      exp_seq++;
      check("seq", 32'(seq), 32'(exp_seq));
      check("busy_lo", 32'(busy), 32'd0);
      repeat (hold - 1) step();
      uart_send_comlete = 1'b0;
      step();
   endtask
   initial begin
      repeat (3) step();
      check("rst_flag", 32'(uart_send_flag), 32'd0);
      check("rst_dataT", dataT, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_seq", 32'(seq), 32'd0);
      check("rst_err", 32'(tx_err), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);
      rst_n = 1'b1;
      step();
      // first two frames against literal values, then random frames up to the seq wrap
      do_frame(8'h3C, 2, 1, fr);
      check("t1_frame", fr, 32'hA5003CE1);
      check("t1_seq", 32'(seq), 32'd1);
      do_frame(8'h3C, 3, 2, fr);
      check("t2_frame", fr, 32'hA5013CE2);
      while (exp_seq != 8'hFF) do_frame(8'($urandom), int'($urandom_range(1, 6)), int'($urandom_range(1, 3)), fr);
      check("seq_ff", 32'(seq), 32'hFF);
      do_frame(8'($urandom), 2, 1, fr);
      check("wrap_frame_seq", 32'(fr[23:16]), 32'hFF);
      check("seq_wrap", 32'(seq), 32'h00);
      // three back-to-back requests: one served, one pending, one dropped
      payload = 8'($urandom);
      fr = model_frame(exp_seq, payload);
      trig = 1'b1;
      repeat (3) step();
      trig = 1'b0;
      wait_flag(n);
      check("t3_latency", 32'(n), 32'd1);
      check("t3_frame1", dataT, fr);
      payload = 8'($urandom);
      step();
      uart_send_comlete = 1'b1;
      step();
      uart_send_comlete = 1'b0;
      exp_seq++;
      check("t3_busy_pend", 32'(busy), 32'd1);
      wait_flag(n);
      check("t3_latency2", 32'(n), 32'(BSN - 1));
      check("t3_frame2", dataT, model_frame(exp_seq, payload));
      step();
      uart_send_comlete = 1'b1;
      step();
      uart_send_comlete = 1'b0;
      exp_seq++;
      check("t3_seq", 32'(seq), 32'(exp_seq));
      check("t3_drop", 32'(drop_cnt), 32'd1);
      run(40, nf);
      check("t3_frames_after", 32'(nf), 32'd0);
      check("t3_busy_lo", 32'(busy), 32'd0);
      // timeout, with a completion edge placed in the FIRE cycle that must be ignored
      payload = 8'($urandom);
      trig = 1'b1;
      step();
      trig = 1'b0;
      wait_flag(n);
      uart_send_comlete = 1'b1;
      n = 0;
      while (!tx_err && n < 200) begin
         step();
         n++;
      end
      check("t4_to_latency", 32'(n), 32'(TIMEOUT_CYC + 1));
      check("t4_seq", 32'(seq), 32'(exp_seq));
      check("t4_busy", 32'(busy), 32'd0);
      uart_send_comlete = 1'b0;
      step();
      check("t4_err_pulse", 32'(tx_err), 32'd0);
      // completion edge in the very cycle the timeout is reached
      trig = 1'b1;
      step();
      trig = 1'b0;
      wait_flag(n);
      repeat (TIMEOUT_CYC) step();
      uart_send_comlete = 1'b1;
      step();
      exp_seq++;
      check("t4b_seq", 32'(seq), 32'(exp_seq));
      check("t4b_no_err", 32'(tx_err), 32'd0);
      check("t4b_busy", 32'(busy), 32'd0);
      uart_send_comlete = 1'b0;
      step();
      // periodic ticks, first one coincident with a trig
      periodic_en = 1'b1;
      payload = 8'($urandom);
      repeat (TICK_N - 1) step();
      trig = 1'b1;
      step();
      trig = 1'b0;
      wait_flag(n);
      check("t5_latency", 32'(n), 32'(BSN - 1));
      check("t5_frame", dataT, model_frame(exp_seq, payload));
      step();
      uart_send_comlete = 1'b1;
      step();
      uart_send_comlete = 1'b0;
      exp_seq++;
      run(TICK_N, nf);
      check("t5_one_tick_frame", 32'(nf), 32'd1);
      check("t5_seq", 32'(seq), 32'(exp_seq));
      periodic_en = 1'b0;
      run(2 * TICK_N + 10, nf);
      check("t5_disabled", 32'(nf), 32'd0);
      check("t5_drop", 32'(drop_cnt), 32'd1);
      // asynchronous reset while waiting for completion
      trig = 1'b1;
      step();
      trig = 1'b0;
      wait_flag(n);
      step();
      #3 rst_n = 1'b0;
      #1;
      check("t6_flag", 32'(uart_send_flag), 32'd0);
      check("t6_dataT", dataT, 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_seq", 32'(seq), 32'd0);
      check("t6_drop", 32'(drop_cnt), 32'd0);
      check("t6_err", 32'(tx_err), 32'd0);
      #2 rst_n = 1'b1;
      exp_seq = '0;
      run(30, nf);
      check("t6_no_flag", 32'(nf), 32'd0);
      do_frame(8'($urandom), 2, 1, fr);
      check("t6_seq_after", 32'(seq), 32'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
